// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
package mole_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_SPAWN,
    ST_UP,
    ST_OVER
  } state_t;

  localparam int          NUM_HOLES = 9;
  localparam logic [3:0]  SCORE_MAX = 4'd15;

  // Right-shifting Galois taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  // Fold a raw 4-bit random value onto holes 0..8 and step past the
  // previous hole so the same hole never comes up twice in a row.
  function automatic logic [3:0] pick_hole(input logic [3:0] raw, input logic [3:0] prev);
    logic [3:0] p;
    p = (raw >= 4'd9) ? (raw - 4'd9) : raw;
    if (p == prev) begin
      p = (p == 4'd8) ? 4'd0 : (p + 4'd1);
    end
    return p;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Galois LFSR used as the mole position source.
module mole_lfsr
  import mole_game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state
);

  // Shift right; when the bit falling out is 1, fold the taps back in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEED;
    end else if (en) begin
      state <= state[0] ? ((state >> 1) ^ LFSR_POLY) : (state >> 1);
    end
  end

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: raises one mole at a time, scores hits,
// and runs a fixed-length game timer.
// Optional build macro: MISS_PENALTY_EN -- wrong-hole presses in UP and any
// press in GAP take one point off the score (floor 0).
module mole_game_ctrl
  import mole_game_pkg::*;
#(
  parameter int          TICK_DIV   = 10_000_000,
  parameter int          MOLE_TICKS = 8,
  parameter int          GAP_TICKS  = 3,
  parameter int          GAME_TICKS = 300,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] hit,
  output logic [8:0] map,
  output logic [3:0] score,
  output logic [8:0] time_left,
  output logic       playing,
  output logic       game_over
);

  localparam int TICK_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int PHASE_MAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

  state_t              state;
  logic [TICK_W-1:0]   tick_cnt;
  logic [PHASE_W-1:0]  phase_cnt;
  logic [3:0]          pos_prev;
  logic [15:0]         lfsr_state;
  logic                unused_lfsr_hi;

  logic                tick;
  logic                game_start;
  logic                mole_hit;
  logic [3:0]          spawn_pos;
  logic [3:0]          score_next;
  logic [NUM_HOLES-1:0] hit_on_mole;

  // Free-running random source; advancing in every state means the
  // moment the player presses start decides the mole sequence.
  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .state (lfsr_state)
  );

  // Only the low nibble picks a hole; the rest is just LFSR state.
  assign unused_lfsr_hi = ^lfsr_state[15:4];

  assign spawn_pos  = pick_hole(lfsr_state[3:0], pos_prev);
  assign game_start = start && !playing;
  assign tick       = playing && (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Per-hole match of a press against the currently raised mole
  for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_hole
    assign hit_on_mole[gi] = hit[gi] && (pos_prev == 4'(gi));
  end

  assign mole_hit = (state == ST_UP) && (|hit_on_mole);

`ifdef MISS_PENALTY_EN
  logic wrong_hit;
  assign wrong_hit = ((state == ST_UP) || (state == ST_GAP)) && (|hit) && !mole_hit;
`endif

  // Score after this cycle's presses: a mole hit saturates upward, and with
  // the penalty build a wrong press takes one point off (never below 0).
  always_comb begin
    score_next = score;
    if (mole_hit) begin
      score_next = (score == SCORE_MAX) ? SCORE_MAX : (score + 4'd1);
    end
`ifdef MISS_PENALTY_EN
    else if (wrong_hit) begin
      score_next = (score == 4'd0) ? 4'd0 : (score - 4'd1);
    end
`endif
  end

  // Game tick prescaler: restarts with each game, frozen when not playing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (game_start) begin
      tick_cnt <= '0;
    end else if (playing) begin
      tick_cnt <= tick ? '0 : (tick_cnt + TICK_W'(1));
    end
  end

  // Game FSM with registered outputs; the game timer block at the bottom
  // overrides whatever phase transition the case statement picked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      map       <= '0;
      score     <= '0;
      time_left <= '0;
      phase_cnt <= '0;
      pos_prev  <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_OVER: begin
          map <= '0;
          if (start) begin
            state     <= ST_GAP;
            score     <= '0;
            time_left <= 9'(GAME_TICKS);
            phase_cnt <= PHASE_W'(GAP_TICKS);
            playing   <= 1'b1;
            game_over <= 1'b0;
          end
        end

        ST_GAP: begin
          map <= '0;
          if (tick) begin
            if (phase_cnt == PHASE_W'(1)) begin
              state <= ST_SPAWN;
            end else begin
              phase_cnt <= phase_cnt - PHASE_W'(1);
            end
          end
        end

        ST_SPAWN: begin
          map       <= 9'(1) << spawn_pos;
          pos_prev  <= spawn_pos;
          phase_cnt <= PHASE_W'(MOLE_TICKS);
          state     <= ST_UP;
        end

        ST_UP: begin
          // A hit takes priority over a tick in the same cycle
          if (mole_hit) begin
            map       <= '0;
            phase_cnt <= PHASE_W'(GAP_TICKS);
            state     <= ST_GAP;
          end else if (tick) begin
            if (phase_cnt == PHASE_W'(1)) begin
              map       <= '0;
              phase_cnt <= PHASE_W'(GAP_TICKS);
              state     <= ST_GAP;
            end else begin
              phase_cnt <= phase_cnt - PHASE_W'(1);
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          map       <= '0;
          playing   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase

      if (playing) begin
        // Scoring still applies on the cycle the game ends
        score <= score_next;
        if (tick) begin
          if (time_left == 9'd1) begin
            time_left <= '0;
            map       <= '0;
            state     <= ST_OVER;
            playing   <= 1'b0;
            game_over <= 1'b1;
          end else begin
            time_left <= time_left - 9'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Self-checking bench for mole_game_ctrl: a behavioural game model runs
// alongside two DUT instances (short and long game) and is compared with
// both every cycle; literal expectations pin the key timings.
`timescale 1ns/1ps
module tb_mole_game_ctrl;

  localparam int TD     = 4;
  localparam int MT     = 3;
  localparam int GT     = 2;
  localparam int GAME_A = 20;
  localparam int GAME_B = 100;

  localparam int M_IDLE  = 0;
  localparam int M_GAP   = 1;
  localparam int M_SPAWN = 2;
  localparam int M_UP    = 3;
  localparam int M_OVER  = 4;

  typedef struct {
    int          mode;
    int          sub;
    int          phase;
    int          tleft;
    int          score;
    int          mole;
    int          prev;
    logic [15:0] lfsr;
  } mst_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_v [2];
  logic [8:0] hit_v   [2];
  logic [8:0] d_map   [2];
  logic [3:0] d_score [2];
  logic [8:0] d_time  [2];
  logic       d_play  [2];
  logic       d_over  [2];

  mst_t m [2];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mole_game_ctrl #(
    .TICK_DIV(TD), .MOLE_TICKS(MT), .GAP_TICKS(GT), .GAME_TICKS(GAME_A), .LFSR_SEED(16'hACE1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .hit(hit_v[0]),
    .map(d_map[0]), .score(d_score[0]), .time_left(d_time[0]),
    .playing(d_play[0]), .game_over(d_over[0])
  );

  mole_game_ctrl #(
    .TICK_DIV(TD), .MOLE_TICKS(MT), .GAP_TICKS(GT), .GAME_TICKS(GAME_B), .LFSR_SEED(16'h1234)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .hit(hit_v[1]),
    .map(d_map[1]), .score(d_score[1]), .time_left(d_time[1]),
    .playing(d_play[1]), .game_over(d_over[1])
  );

  function automatic mst_t model_reset(input int k);
    mst_t r;
    r.mode = M_IDLE; r.sub = 0; r.phase = 0; r.tleft = 0;
    r.score = 0; r.mole = -1; r.prev = 0;
    r.lfsr = (k == 0) ? 16'hACE1 : 16'h1234;
    return r;
  endfunction

  // One clock of the game rules, written from the behavioural description
  function automatic mst_t model_step(input mst_t s, input logic st, input logic [8:0] h, input int glen);
    mst_t n;
    bit   live, tk, on_mole;
    int   p;
    n       = s;
    live    = (s.mode == M_GAP) || (s.mode == M_SPAWN) || (s.mode == M_UP);
    tk      = live && (s.sub == TD - 1);
    on_mole = (s.mode == M_UP) && (h[s.prev] == 1'b1);
    n.lfsr  = s.lfsr[0] ? ((s.lfsr >> 1) ^ 16'hB400) : (s.lfsr >> 1);
    if (!live) begin
      if (st) begin
        n.mode = M_GAP; n.score = 0; n.tleft = glen; n.phase = GT; n.mole = -1; n.sub = 0;
      end
      return n;
    end
    n.sub = (s.sub + 1) % TD;
    if (on_mole) n.score = (s.score < 15) ? s.score + 1 : 15;
`ifdef MISS_PENALTY_EN
    else if ((h != 9'd0) && ((s.mode == M_UP) || (s.mode == M_GAP)))
      n.score = (s.score > 0) ? s.score - 1 : 0;
`endif
    if (s.mode == M_GAP) begin
      if (tk) begin
        if (s.phase == 1) n.mode = M_SPAWN;
        else n.phase = s.phase - 1;
      end
    end else if (s.mode == M_SPAWN) begin
      p = int'(s.lfsr[3:0]) % 9;
      if (p == s.prev) p = (p + 1) % 9;
      n.mole = p; n.prev = p; n.phase = MT; n.mode = M_UP;
    end else begin
      if (on_mole || (tk && s.phase == 1)) begin
        n.mole = -1; n.phase = GT; n.mode = M_GAP;
      end else if (tk) begin
        n.phase = s.phase - 1;
      end
    end
    if (tk) begin
      if (s.tleft == 1) begin
        n.tleft = 0; n.mole = -1; n.mode = M_OVER;
      end else begin
        n.tleft = s.tleft - 1;
      end
    end
    return n;
  endfunction

  function automatic logic [8:0] exp_map(input mst_t s);
    return (s.mole < 0) ? 9'd0 : (9'(1) << s.mole);
  endfunction

  // Model state advances on the same edges as the DUTs
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m[0] <= model_reset(0);
      m[1] <= model_reset(1);
    end else begin
      m[0] <= model_step(m[0], start_v[0], hit_v[0], GAME_A);
      m[1] <= model_step(m[1], start_v[1], hit_v[1], GAME_B);
    end
  end

  // Per-cycle comparison of both DUTs against the model
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (d_map[k] !== exp_map(m[k]) || d_score[k] !== 4'(m[k].score) ||
            d_time[k] !== 9'(m[k].tleft) ||
            d_play[k] !== ((m[k].mode == M_GAP) || (m[k].mode == M_SPAWN) || (m[k].mode == M_UP)) ||
            d_over[k] !== (m[k].mode == M_OVER)) begin
          errors++;
          $display("FAIL model_cmp dut%0d t=%0t map=%b/%b score=%0d/%0d time_left=%0d/%0d playing=%b/%0d game_over=%b/%0d (actual/required)",
                   k, $time, d_map[k], exp_map(m[k]), d_score[k], m[k].score, d_time[k], m[k].tleft,
                   d_play[k], int'((m[k].mode >= M_GAP) && (m[k].mode <= M_UP)),
                   d_over[k], int'(m[k].mode == M_OVER));
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Wait (bounded) for the map to become nonzero (want_up=1) or zero
  task automatic wait_map(input int k, input bit want_up, output int n);
    n = 0;
    while (((d_map[k] != 9'd0) != want_up) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL wait_map dut%0d want_up=%0b actual_map=%b required=%s", k, want_up, d_map[k],
               want_up ? "nonzero" : "zero");
    end
  endtask

  task automatic press(input int k, input logic [8:0] mask);
    hit_v[k] = mask;
    @(negedge clk);
    hit_v[k] = 9'd0;
    $display("hit dut%0d mask=%b score=%0d map=%b", k, mask, d_score[k], d_map[k]);
  endtask

  task automatic pulse_start(input int k);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    $display("start dut%0d playing=%b time_left=%0d", k, d_play[k], d_time[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog bench did not finish, actual_time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s, prev, mole;
    logic [8:0] wrong;
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    hit_v[0]   = 9'd0; hit_v[1]   = 9'd0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // 1: idle after reset, then start and first mole latency
    repeat (10) @(negedge clk);
    check("idle_map", d_map[0], 0);
    check("idle_score", d_score[0], 0);
    check("idle_time_left", d_time[0], 0);
    check("idle_playing", d_play[0], 0);
    pulse_start(0);
    s = cyc;
    check("start_playing", d_play[0], 1);
    check("start_time_left", d_time[0], GAME_A);
    wait_map(0, 1'b1, n);
    check("first_mole_latency", n, 2 * TD + 1);
    check("first_mole_onehot", int'($onehot(d_map[0])), 1);

    // 2: hit the mole, next mole must use a different hole
    mole = m[0].mole;
    prev = mole;
    press(0, 9'(1) << mole);
    check("hit_score", d_score[0], 1);
    check("hit_clears_map", d_map[0], 0);
    wait_map(0, 1'b1, n);
    check("new_hole_differs", int'(d_map[0] == (9'(1) << prev)), 0);

    // 3: let it expire, then hit with all bits
    wait_map(0, 1'b0, n);
    check("miss_keeps_score", d_score[0], 1);
    wait_map(0, 1'b1, n);
    press(0, 9'h1FF);
    check("all_bits_hit_score", d_score[0], 2);

    // 5: start while playing is ignored; run to the end
    pulse_start(0);
    check("start_ignored_score", d_score[0], 2);
    check("start_ignored_playing", d_play[0], 1);
    while (!d_over[0] && (cyc - s) < 300) @(negedge clk);
    check("game_length_cycles", cyc - s, GAME_A * TD);
    check("over_flag", d_over[0], 1);
    check("over_time_left", d_time[0], 0);
    check("over_map", d_map[0], 0);
    check("over_playing", d_play[0], 0);
    repeat (3) @(negedge clk);
    check("over_holds_score", d_score[0], 2);
    pulse_start(0);
    check("restart_score", d_score[0], 0);
    check("restart_time_left", d_time[0], GAME_A);
    check("restart_game_over", d_over[0], 0);

    // 6: asynchronous reset in the middle of UP
    wait_map(0, 1'b1, n);
    press(0, 9'(1) << m[0].mole);
    check("pre_reset_score", d_score[0], 1);
    wait_map(0, 1'b1, n);
    #2 rst = 1'b0;
    #1;
    check("areset_map", d_map[0], 0);
    check("areset_score", d_score[0], 0);
    check("areset_time_left", d_time[0], 0);
    check("areset_playing", d_play[0], 0);
    @(negedge clk);
    rst = 1'b1;

    // 4: saturation over 16 hits on the long game
    pulse_start(1);
    for (int i = 0; i < 16; i++) begin
      wait_map(1, 1'b1, n);
      press(1, 9'(1) << m[1].mole);
      check("sat_score", d_score[1], (i < 15) ? i + 1 : 15);
      check("sat_map_clear", d_map[1], 0);
    end

    // Wrong-hole presses from a score of 2
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pulse_start(1);
    for (int i = 0; i < 2; i++) begin
      wait_map(1, 1'b1, n);
      press(1, 9'(1) << m[1].mole);
    end
    check("wrong_setup_score", d_score[1], 2);
    wait_map(1, 1'b1, n);
    mole  = m[1].mole;
    wrong = 9'h1FF & ~(9'(1) << mole);
    for (int i = 0; i < 3; i++) begin
      press(1, wrong);
`ifdef MISS_PENALTY_EN
      check("penalty_score", d_score[1], (i == 0) ? 1 : 0);
`else
      check("wrong_ignored_score", d_score[1], 2);
`endif
    end
    check("wrong_hit_mole_stays", d_map[1], 9'(1) << mole);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
Game sequencer for the whack-a-mole datapath. It raises one mole at a time on the 9-hole map and scores debounced hole-button hits. It runs a fixed-length game timer and drives the 9-bit map and 4-bit score buses consumed by the display top. It sits between the button front-end (debounce/one-pulse) and the display/seven-segment block.

Parameters:
TICK_DIV, 10_000_000, clk cycles per game tick (0.1 s at 100 MHz); must be >= 2
MOLE_TICKS, 8, ticks a mole stays up before it counts as a miss
GAP_TICKS, 3, ticks with empty map between moles
GAME_TICKS, 300, game length in ticks; must be 1..511
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse that starts or restarts a game
hit  input  9  one-cycle pulses, one bit per hole; multiple bits may be set together
map  output  9  one-hot active mole position, or all zero
score  output  4  hits this game, saturating at 15
time_left  output  9  remaining game ticks
playing  output  1  high in GAP/SPAWN/UP
game_over  output  1  high in OVER

Behaviour:
- Reset (rst low, async): state IDLE, map=0, score=0, time_left=0, all counters 0, LFSR=LFSR_SEED, pos_prev=0.
- States: IDLE, GAP, SPAWN, UP, OVER. All outputs are registered.
- Tick generator:
  - tick_cnt runs only while playing and counts 0..TICK_DIV-1.
  - tick is a 1-cycle strobe when tick_cnt==TICK_DIV-1.
  - tick_cnt is cleared on game start.
- IDLE/OVER + start:
  - Next cycle: state=GAP, score=0, time_left=GAME_TICKS, phase_cnt=GAP_TICKS, map=0.
  - start while playing is ignored.
- GAP: map=0. On tick, phase_cnt decrements. When phase_cnt is 1 on a tick, go to SPAWN.
- SPAWN (exactly 1 cycle):
  - Position selection: p = lfsr[3:0]; if p>=9 then p=p-9. If p==pos_prev then p=(p==8)?0:p+1.
  - Next cycle: map=1<<p, pos_prev=p, phase_cnt=MOLE_TICKS, state=UP.
- UP:
  - Hit: if hit[pos_prev]==1, next cycle score=min(score+1,15), map=0, phase_cnt=GAP_TICKS, state=GAP. Other hit bits are ignored.
  - Expiry: otherwise, on a tick phase_cnt decrements. When it is 1 on a tick, the mole is missed: map=0, phase_cnt=GAP_TICKS, GAP. Score is unchanged.
  - A hit and a tick in the same cycle: the hit wins.
- Game timer:
  - In any playing state, each tick decrements time_left.
  - A tick with time_left==1 sets time_left=0, map=0 and state=OVER. This overrides any GAP/SPAWN/UP transition in the same cycle.
  - A valid hit in that same cycle is still scored.
- OVER: map=0, score held, game_over=1, waits for start.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle in all states, so the start time seeds variety.
- Score saturation: at 15 a further hit keeps score at 15 but still clears the mole.
- Reset mid-game returns to IDLE immediately with all outputs at their reset values.

Optional Feature:
MISS_PENALTY_EN
- Defined: in UP, a cycle with any hit bit set other than hit[pos_prev] (and hit[pos_prev]=0) decrements score, floor 0. The mole stays up. In GAP, any hit bit decrements score, floor 0. One decrement per cycle regardless of how many bits are set.
- Undefined: wrong hits are ignored entirely.

Decomposition:
- Package mole_game_pkg: state enum type; NUM_HOLES=9; SCORE_MAX=4'd15; LFSR polynomial constant.
- Sub-module mole_lfsr: the 16-bit Galois LFSR with seed parameter, enable input and 16-bit state output.
- Tick generator, FSM and score logic stay in mole_game_ctrl.

Test Plan (TICK_DIV=4, MOLE_TICKS=3, GAP_TICKS=2, GAME_TICKS=20):
1. Release reset, idle 10 cycles -> map=0, score=0, time_left=0, playing=0; start pulse -> next cycle playing=1, time_left=20; first map nonzero (one-hot) at 2 ticks + 1 cycle after start.
2. Map=9'b000010000, pulse hit=9'b000010000 -> next cycle score=1, map=0; a new mole appears after 2 ticks and is not hole 4.
3. Mole up, no hits -> map clears after exactly 3 ticks, score unchanged; hit=9'b111111111 including the mole bit -> score+1.
4. Force 16 consecutive valid hits -> score sequence 1..15 then stays 15, mole still cleared on the 16th.
5. Run to end -> on the 20th tick time_left=0, game_over=1, map=0; start ignored while playing; start in OVER -> score=0, time_left=20.
6. Assert rst mid-UP -> map=0, score=0, state IDLE asynchronously. With MISS_PENALTY_EN: score=2, wrong-hole hit -> 1, two more -> 0, floor holds.
